// File: rtl/uart_pkg.sv
// Shared UART package: state encoding, oversampling default, data width and
// a small 2-of-3 majority helper used by the receiver's filtered build.
package uart_pkg;

   localparam int OVERSAMPLE_DEFAULT = 16;
   localparam int DATA_W             = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      START = 2'b01,
      DATA  = 2'b10,
      STOP  = 2'b11
   } uart_state_t;

   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input. Both flops
// reset high so an idle-high line never shows a false low after reset.
module uart_rx_sync (
   input  logic clk,
   input  logic reset,
   input  logic async_in,
   output logic sync_out
);

   logic meta;

   // Capture the asynchronous input and re-register it to settle metastability
   always_ff @(posedge clk) begin
      if (reset) begin
         meta     <= 1'b1;
         sync_out <= 1'b1;
      end else begin
         meta     <= async_in;
         sync_out <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver. Oversamples the synchronized line with os_tick, checks
// the start bit at mid-bit, shifts in eight data bits LSB-first and decides
// the stop bit at its middle, producing a one-cycle valid or framing-error
// pulse. Optional build macro: UART_RX_MAJORITY_EN replaces each single-sample
// decision with a 2-of-3 vote over the last three ticks.
module uart_rx
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              os_tick,
   input  logic              rx,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   output logic              rx_frame_err,
   output logic              rx_busy
);

   localparam int CW = $clog2(OVERSAMPLE);
   localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE / 2 - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);

   uart_state_t       state;
   uart_state_t       next_state;
   logic [CW-1:0]     cnt;
   logic [2:0]        idx;
   logic [DATA_W-1:0] sh;
   logic              armed;
   logic              rx_s;
   logic              sample;

   uart_rx_sync u_sync (
      .clk      (clk),
      .reset    (reset),
      .async_in (rx),
      .sync_out (rx_s)
   );

`ifdef UART_RX_MAJORITY_EN
   logic [1:0] hist;

   // Keep the two previous tick samples so a decision can vote over three
   always_ff @(posedge clk) begin
      if (reset) begin
         hist <= 2'b11;
      end else if (os_tick) begin
         hist <= {hist[0], rx_s};
      end
   end

   assign sample = majority3(hist[1], hist[0], rx_s);
`else
   assign sample = rx_s;
`endif

   assign rx_busy = (state != IDLE);

   // Next-state decision, evaluated only on oversampling ticks
   always_comb begin
      next_state = state;
      if (os_tick) begin
         case (state)
            IDLE:  if (!rx_s && armed) next_state = START;
            START: if (cnt == CNT_HALF) next_state = sample ? IDLE : DATA;
            DATA:  if (cnt == CNT_LAST && idx == 3'd7) next_state = STOP;
            STOP:  if (cnt == CNT_LAST) next_state = IDLE;
            default: next_state = IDLE;
         endcase
      end
   end

   // State register; reset abandons any partial frame
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Bit timing, data assembly, re-arm tracking and the registered result pulses
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt          <= '0;
         idx          <= '0;
         sh           <= '0;
         armed        <= 1'b0;
         rx_data      <= '0;
         rx_valid     <= 1'b0;
         rx_frame_err <= 1'b0;
      end else begin
         rx_valid     <= 1'b0;
         rx_frame_err <= 1'b0;
         if (os_tick) begin
            case (state)
               IDLE: begin
                  cnt <= '0;
                  if (rx_s) armed <= 1'b1;
               end
               START: begin
                  if (cnt == CNT_HALF) begin
                     cnt <= '0;
                     idx <= '0;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
               DATA: begin
                  if (cnt == CNT_LAST) begin
                     cnt <= '0;
                     sh  <= {sample, sh[DATA_W-1:1]};
                     if (idx != 3'd7) idx <= idx + 3'd1;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
               STOP: begin
                  if (cnt == CNT_LAST) begin
                     cnt <= '0;
                     if (sample) begin
                        rx_data  <= sh;
                        rx_valid <= 1'b1;
                     end else begin
                        rx_frame_err <= 1'b1;
                        armed        <= 1'b0;
                     end
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
               default: cnt <= '0;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard testbench for uart_rx: stimulus pushes the expected frame result
// into a queue, an independent monitor pops and compares on every output pulse.
module tb_uart_rx;

   localparam int OS  = 16;
   localparam int BIT = 64;

   typedef struct {
      logic       err;
      logic [7:0] data;
   } exp_t;

   logic       clk;
   logic       reset;
   logic       os_tick;
   logic       rx;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_frame_err;
   logic       rx_busy;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_compared;
   int   n_mismatched;

   uart_rx #(.OVERSAMPLE(OS)) dut (
      .clk          (clk),
      .reset        (reset),
      .os_tick      (os_tick),
      .rx           (rx),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .rx_frame_err (rx_frame_err),
      .rx_busy      (rx_busy)
   );

   // 10 ns system clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Oversampling tick: one clk cycle high every 4 clk cycles
   initial begin
      os_tick = 1'b0;
      forever begin
         repeat (3) @(posedge clk);
         #1 os_tick = 1'b1;
         @(posedge clk);
         #1 os_tick = 1'b0;
      end
   end

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_compared++;
      if (actual !== expected) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
      end
   endtask

   // Monitor: every pulse is matched against the oldest expected result
   always @(negedge clk) begin
      if (!reset && (rx_valid || rx_frame_err)) begin
         n_compared++;
         if (exp_q.size() == 0) begin
            n_mismatched++;
            $display("[TB] FAIL unexpected_pulse: got valid=%0b err=%0b data=0x%0h expected no pulse",
                     rx_valid, rx_frame_err, rx_data);
         end else begin
            mon_e = exp_q.pop_front();
            if (mon_e.err) begin
               if (!(rx_frame_err === 1'b1 && rx_valid === 1'b0)) begin
                  n_mismatched++;
                  $display("[TB] FAIL frame_err_pulse: got valid=%0b err=%0b expected valid=0 err=1",
                           rx_valid, rx_frame_err);
               end
            end else begin
               if (!(rx_valid === 1'b1 && rx_frame_err === 1'b0 && rx_data === mon_e.data)) begin
                  n_mismatched++;
                  $display("[TB] FAIL rx_byte: got valid=%0b err=%0b data=0x%0h expected valid=1 err=0 data=0x%0h",
                           rx_valid, rx_frame_err, rx_data, mon_e.data);
               end
            end
         end
      end
   end

   // Wait for a clk edge on which os_tick is sampled high, then step 1 ns past it
   task automatic align_to_tick();
      do @(posedge clk); while (os_tick !== 1'b1);
      #1;
   endtask

   // One bit time; optional one-tick inverted glitch aimed at the D-1 sample
   task automatic drive_bit(input logic v, input bit glitch);
      rx = v;
      if (glitch) begin
         repeat (28) @(posedge clk);
         #1 rx = ~v;
         repeat (4) @(posedge clk);
         #1 rx = v;
         repeat (32) @(posedge clk);
         #1;
      end else begin
         repeat (BIT) @(posedge clk);
         #1;
      end
   endtask

   task automatic idle_bits(input int n);
      rx = 1'b1;
      repeat (n * BIT) @(posedge clk);
      #1;
   endtask

   // Queue the expected outcome, then drive a complete frame
   task automatic apply_stimulus(input logic [7:0] data, input logic stop_bit,
                                 input bit align, input bit glitch);
      exp_t e;
      e.err  = ~stop_bit;
      e.data = data;
      exp_q.push_back(e);
      if (align) align_to_tick();
      drive_bit(1'b0, 1'b0);
      for (int i = 0; i < 8; i++) drive_bit(data[i], glitch);
      drive_bit(stop_bit, 1'b0);
   endtask

   initial begin
      exp_t e;
      n_compared   = 0;
      n_mismatched = 0;
      rx    = 1'b1;
      reset = 1'b1;
      repeat (5) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check_output("reset_rx_data", 32'(rx_data), 32'h00);
      check_output("reset_rx_valid", 32'(rx_valid), 32'h0);
      check_output("reset_rx_frame_err", 32'(rx_frame_err), 32'h0);
      check_output("reset_rx_busy", 32'(rx_busy), 32'h0);
      #1;
      idle_bits(2);

      $display("[TB] single frame 0xA5");
      apply_stimulus(8'hA5, 1'b1, 1'b1, 1'b0);
      idle_bits(1);
      check_output("single_busy_low", 32'(rx_busy), 32'h0);
      check_output("single_data_hold", 32'(rx_data), 32'hA5);

      $display("[TB] back-to-back 0x00 then 0xFF");
      apply_stimulus(8'h00, 1'b1, 1'b1, 1'b0);
      apply_stimulus(8'hFF, 1'b1, 1'b0, 1'b0);
      idle_bits(1);

      $display("[TB] start glitch");
      align_to_tick();
      rx = 1'b0;
      repeat (12) @(posedge clk);
      #1 check_output("glitch_busy_high", 32'(rx_busy), 32'h1);
      rx = 1'b1;
      repeat (50) @(posedge clk);
      #1 check_output("glitch_busy_low", 32'(rx_busy), 32'h0);
      idle_bits(1);

      $display("[TB] bad stop bit after good 0x11");
      apply_stimulus(8'h11, 1'b1, 1'b1, 1'b0);
      idle_bits(1);
      apply_stimulus(8'h3C, 1'b0, 1'b1, 1'b0);
      idle_bits(2);
      check_output("bad_stop_data_hold", 32'(rx_data), 32'h11);

      $display("[TB] break then 0x5A");
      e.err  = 1'b1;
      e.data = 8'h00;
      exp_q.push_back(e);
      align_to_tick();
      rx = 1'b0;
      repeat (30 * BIT) @(posedge clk);
      #1;
      idle_bits(2);
      apply_stimulus(8'h5A, 1'b1, 1'b1, 1'b0);
      idle_bits(1);
      check_output("break_next_data", 32'(rx_data), 32'h5A);

      $display("[TB] reset during data bit 4");
      align_to_tick();
      drive_bit(1'b0, 1'b0);
      for (int i = 0; i < 4; i++) drive_bit(1'b1, 1'b0);
      rx = 1'b1;
      repeat (20) @(posedge clk);
      #1 reset = 1'b1;
      repeat (4) @(posedge clk);
      #1 reset = 1'b0;
      check_output("midreset_busy_low", 32'(rx_busy), 32'h0);
      check_output("midreset_data_cleared", 32'(rx_data), 32'h00);
      idle_bits(2);
      apply_stimulus(8'h81, 1'b1, 1'b1, 1'b0);
      idle_bits(1);
      check_output("midreset_next_data", 32'(rx_data), 32'h81);

`ifdef UART_RX_MAJORITY_EN
      $display("[TB] majority vote against mid-bit glitches, 0xC3");
      apply_stimulus(8'hC3, 1'b1, 1'b1, 1'b1);
      idle_bits(1);
      check_output("majority_data", 32'(rx_data), 32'hC3);
`endif

      idle_bits(2);
      check_output("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous 8N1 serial receiver, the receive-side counterpart of the team's UART transmitter. It oversamples the `rx` line using a shared oversampling tick and validates the start bit at mid-bit. It assembles eight data bits LSB-first and checks the stop bit. Each frame produces either a one-cycle data-valid pulse or a one-cycle framing-error pulse for the host-side logic (FIFO or command decoder).

## Interface
- `OVERSAMPLE`, default 16: ticks per bit. Must be even and ≥ 8.
- `clk`, input, 1: system clock. All logic is rising-edge.
- `reset`, input, 1: synchronous, active-high.
- `os_tick`, input, 1: one-`clk` pulse at `OVERSAMPLE` × baud rate, from the baud generator.
- `rx`, input, 1: asynchronous serial line. Idle level is high.
- `rx_data`, output, 8: last correctly received byte. Holds its value until the next good frame.
- `rx_valid`, output, 1: one-cycle pulse when `rx_data` is updated.
- `rx_frame_err`, output, 1: one-cycle pulse when the stop bit is sampled low.
- `rx_busy`, output, 1: high in every state other than IDLE.

## Operation
- **Synchronizer:** `rx` passes through two flops, giving `rx_s`. Both flops reset to 1.
- **Bit-tick counter `cnt`:** width `$clog2(OVERSAMPLE)`. It advances only on `os_tick`.
- **Bit index `idx`:** 3 bits.
- **Shift register `sh`:** 8 bits. It shifts right, inserting each sampled bit at bit 7, so the frame ends LSB-aligned.
- **Sample value:** the value of `rx_s` at the decision tick.
- **State IDLE:**
  - If `os_tick`, `rx_s` = 0 and `armed` = 1: go to START with `cnt` = 0.
  - `armed` is set whenever `rx_s` = 1 is seen in IDLE.
  - `armed` is cleared on a framing error.
- **State START:** on each tick, `cnt` increments.
  - On the tick where `cnt` = `OVERSAMPLE/2`−1: if the sample is 0, go to DATA with `cnt` = 0 and `idx` = 0. Otherwise go back to IDLE (glitch rejected).
- **State DATA:** on the tick where `cnt` = `OVERSAMPLE`−1, shift the sample into `sh` and clear `cnt`.
  - If `idx` = 7, go to STOP. Otherwise increment `idx`.
- **State STOP:** on the tick where `cnt` = `OVERSAMPLE`−1:
  - Sample 1: `rx_data` ← `sh` and pulse `rx_valid`.
  - Sample 0: pulse `rx_frame_err` and clear `armed`. `rx_data` is unchanged.
  - In both cases, go to IDLE.
- **Framing-error re-arm:** after a framing error the receiver waits for the line to go high. A held-low line (break) therefore yields exactly one error, not a stream of them.
- **Ticks:** `clk` cycles without `os_tick` change nothing except the synchronizer.
- **Reset mid-frame:**
  - The state returns to IDLE.
  - The partial frame is discarded.
  - No pulse is produced.
  - `armed` = 0.

## Timing
- **Reset values:** `rx_data` = 0x00, `rx_valid` = 0, `rx_frame_err` = 0, `rx_busy` = 0.
- **Synchronizer latency:** 2 `clk` cycles from `rx` to `rx_s`.
- **Output registration:** `rx_valid` and `rx_frame_err` are registered. They assert on the `clk` edge that consumes the STOP decision tick and are high for exactly 1 cycle.
- **Data update:** `rx_data` updates on that same edge.
- **Frame length:** about 9.5 bit-times from the start edge to the pulse. The stop decision is at the middle of the stop bit.
- **Back-to-back frames:** the receiver returns to IDLE at mid-stop-bit, so it can catch a start edge from a transmitter with a full stop bit.
- **Output semantics:** there is no backpressure. Each pulse is a single-cycle event, and a consumer that misses it loses the byte.

## Configuration
- **`UART_RX_MAJORITY_EN` defined:**
  - Each decision uses a 2-of-3 majority of `rx_s`.
  - The three samples are taken at ticks `D`−2, `D`−1 and `D`, where `D` is the decision count.
  - Ticks `D`−2 and `D`−1 are stored in a 2-bit history register.
  - This applies to the start-bit check, the data bits and the stop bit.
- **Undefined:** each decision uses the single sample at tick `D`.
- Decision timing is the same in both builds.

## Structure
- **Shared `uart_pkg`:**
  - The state encoding: IDLE = 2'b00, START = 2'b01, DATA = 2'b10, STOP = 2'b11.
  - The `OVERSAMPLE_DEFAULT` = 16 constant.
  - The data-width constant 8, shared with the transmitter.
- **Sub-module `uart_rx_sync`:** the two-flop synchronizer, reset to 1, reusable for other asynchronous inputs.
- **FSM style:** the FSM uses a combinational next-state process and a registered state process, the same as the transmitter.

## Test plan
- **Single frame:** `OVERSAMPLE` = 16, `os_tick` every 4 `clk`, frame 0xA5 driven at 64 `clk` per bit. Expect exactly one `rx_valid`, `rx_data` = 0xA5, `rx_frame_err` never asserted, and `rx_busy` low after the frame.
- **Back-to-back frames:** 0x00 then 0xFF with one stop bit between them. Expect two `rx_valid` pulses carrying 0x00 then 0xFF.
- **Start glitch:** `rx` low for 3 ticks, then high. Expect no pulses, state back in IDLE, and `rx_busy` low before tick 9.
- **Bad stop bit:** frame 0x3C with the stop bit low after a good 0x11 has been received. Expect one `rx_frame_err` pulse, no `rx_valid`, and `rx_data` still 0x11.
- **Break:** `rx` held low for 30 bit-times, then released. Expect one `rx_frame_err` pulse only. The next frame, 0x5A, is received correctly.
- **Reset mid-frame:** assert `reset` during data bit 4, release it, then send 0x81. Expect no pulse from the aborted frame and `rx_data` = 0x81.
- **Majority build:** with `UART_RX_MAJORITY_EN` defined, a one-tick inverted glitch at `cnt` = `D`−1 of every data bit of 0xC3. Expect `rx_data` = 0xC3.
